// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for the lanes touched by an access of the given size.
    function automatic logic [3:0] calc_be(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: calc_be = 4'b0001 << offset;
            F3_H, F3_HU: calc_be = 4'b0011 << {offset[1], 1'b0};
            default:     calc_be = 4'b1111;
        endcase
    endfunction

    // Legal size for the direction and naturally aligned to that size.
    function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                       input logic [1:0] offset);
        case (funct3)
            F3_B:    access_ok = 1'b1;
            F3_H:    access_ok = !offset[0];
            F3_W:    access_ok = (offset == 2'b00);
            F3_BU:   access_ok = !is_store;
            F3_HU:   access_ok = !is_store && !offset[0];
            default: access_ok = 1'b0;
        endcase
    endfunction

    // Copy the store data into every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            F3_B:    replicate_wdata = {4{wdata[7:0]}};
            F3_H:    replicate_wdata = {2{wdata[15:0]}};
            default: replicate_wdata = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a raw bus word and extends it to 32 bits.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by sign or zero extension by access type.
    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'b0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'b0, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a variable-latency bus.
// Optional feature: define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC
// cycles without bus_ready, pulsing bus_err.
//
// Handshake: bus_req rises the cycle after an accepted request and holds
// until the cycle in which bus_ready is sampled high; bus_rdata is only
// looked at in that cycle. stall is high from the request cycle through the
// last BUSY cycle and low in DONE, where the datapath retires the access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             lsu_fault,
    output logic             bus_err,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [3:0]       bus_be,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_ready,
    input  logic [WIDTH-1:0] bus_rdata,
    output lsu_state_e       dbg_state
);

    if (WIDTH != 32 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
        $error("load_store_unit: WIDTH must be 32 and TIMEOUT_CYC 1..255");
    end

    lsu_state_e  state;
    logic [1:0]  req_off;
    logic [2:0]  req_f3;
    logic        req_any;
    logic        req_ok;
    logic        start;
    logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
    logic [7:0] tmo_cnt;
`else
    assign bus_err = 1'b0;
`endif

    assign dbg_state = state;

    // Request decode; write takes priority when both strobes are set.
    always_comb begin
        req_any = mem_read | mem_write;
        req_ok  = access_ok(mem_write, funct3, address[1:0]);
        start   = (state == IDLE) && req_any && req_ok;
        stall   = start || (state == BUSY);
    end

    load_align u_load_align (
        .word   (bus_rdata),
        .offset (req_off),
        .funct3 (req_f3),
        .data   (load_data)
    );

    // Transaction FSM with registered bus outputs and fault/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            lsu_fault <= 1'b0;
            req_off   <= 2'b0;
            req_f3    <= 3'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err   <= 1'b0;
            tmo_cnt   <= 8'd0;
`endif
        end else begin
            lsu_fault <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (req_ok) begin
                            bus_addr  <= {address[WIDTH-1:2], 2'b00};
                            bus_be    <= calc_be(funct3, address[1:0]);
                            bus_we    <= mem_write;
                            bus_wdata <= mem_write ? replicate_wdata(funct3, wdata) : '0;
                            req_off   <= address[1:0];
                            req_f3    <= funct3;
                            bus_req   <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt   <= 8'd0;
`endif
                            state     <= BUSY;
                        end else begin
                            lsu_fault <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata <= load_data;
                        end
                        state <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == TIMEOUT_LIM - 8'd1) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata   <= '0;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    // The datapath still presents the request here; it is retired, not reissued.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a queue-based scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        lsu_fault;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  lsu_state_e  dbg_state;

  int tests = 0;
  int failed = 0;

  logic [31:0] exp_rdata_q[$];
  logic [68:0] exp_bus_q[$];
  logic [31:0] exp_fault_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic [68:0] bus_e;
  logic [31:0] fault_e;
  logic        prev_req = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .lsu_fault (lsu_fault),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver: one datapath access, with the bus answering after 'waits' extra cycles
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] word, input logic legal,
                        input logic [31:0] exp_data, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    @(negedge clk);
    if (legal) begin
      exp_bus_q.push_back({wr, exp_be, a[31:2], 2'b00, exp_wdata});
      if (!wr) last_rdata = exp_data;
      exp_rdata_q.push_back(last_rdata);
    end else begin
      exp_fault_q.push_back(last_rdata);
    end
    mem_read = rd;
    mem_write = wr;
    funct3 = f3;
    address = a;
    wdata = wd;
    #1;
    check("stall on request", {31'b0, stall}, {31'b0, legal});
    if (legal) begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clk); #1;
        check("stall while waiting", {31'b0, stall}, 32'd1);
        check("bus_req while waiting", {31'b0, bus_req}, 32'd1);
      end
      @(negedge clk);
      bus_ready = 1'b1;
      bus_rdata = word;
      #1;
      check("stall in ready cycle", {31'b0, stall}, 32'd1);
      @(negedge clk);
      bus_ready = 1'b0;
      bus_rdata = 32'h5A5A5A5A;
      #1;
      check("stall released", {31'b0, stall}, 32'd0);
      @(negedge clk);
      mem_read = 1'b0;
      mem_write = 1'b0;
      #1;
      check("no reissue bus_req", {31'b0, bus_req}, 32'd0);
      check("back to idle", {30'b0, dbg_state}, {30'b0, IDLE});
    end else begin
      @(negedge clk);
      mem_read = 1'b0;
      mem_write = 1'b0;
      #1;
      check("no bus after fault", {31'b0, bus_req}, 32'd0);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (bus_req && !prev_req) begin
          if (exp_bus_q.size() == 0) begin
            check("unexpected bus_req", 32'd1, 32'd0);
          end else begin
            bus_e = exp_bus_q.pop_front();
            check("bus_we", {31'b0, bus_we}, {31'b0, bus_e[68]});
            check("bus_be", {28'b0, bus_be}, {28'b0, bus_e[67:64]});
            check("bus_addr", bus_addr, bus_e[63:32]);
            check("bus_wdata", bus_wdata, bus_e[31:0]);
          end
        end
        if (dbg_state == DONE) begin
          if (exp_rdata_q.size() == 0) begin
            check("unexpected done", 32'd1, 32'd0);
          end else begin
            check("rdata", rdata, exp_rdata_q.pop_front());
          end
          check("stall in done", {31'b0, stall}, 32'd0);
`ifndef LSU_TIMEOUT_EN
          check("bus_err tied low", {31'b0, bus_err}, 32'd0);
`endif
        end
        if (lsu_fault) begin
          if (exp_fault_q.size() == 0) begin
            check("unexpected lsu_fault", 32'd1, 32'd0);
          end else begin
            fault_e = exp_fault_q.pop_front();
            check("bus_req on fault", {31'b0, bus_req}, 32'd0);
            check("rdata on fault", rdata, fault_e);
          end
        end
      end
      prev_req = bus_req;
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset rdata", rdata, 32'h0);
    check("reset bus_req", {31'b0, bus_req}, 32'd0);
    check("reset bus_we", {31'b0, bus_we}, 32'd0);
    check("reset bus_be", {28'b0, bus_be}, 32'd0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset bus_wdata", bus_wdata, 32'h0);
    check("reset lsu_fault", {31'b0, lsu_fault}, 32'd0);
    check("reset bus_err", {31'b0, bus_err}, 32'd0);
    check("reset state", {30'b0, dbg_state}, {30'b0, IDLE});
    rst = 1'b0;

    //     rd    wr    f3      addr          wdata         w  bus word      legal exp_data      be       exp_wdata
    access(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h00000000, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h00000000);
    access(1'b1, 1'b0, 3'b000, 32'h00000103, 32'h00000000, 1, 32'h80112233, 1'b1, 32'hFFFFFF80, 4'b1000, 32'h00000000);
    access(1'b1, 1'b0, 3'b100, 32'h00000103, 32'h00000000, 0, 32'h80112233, 1'b1, 32'h00000080, 4'b1000, 32'h00000000);
    access(1'b0, 1'b1, 3'b001, 32'h00000202, 32'h1234ABCD, 0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b1100, 32'hABCDABCD);
    access(1'b1, 1'b0, 3'b010, 32'h00000101, 32'h00000000, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000);
    access(1'b1, 1'b0, 3'b001, 32'h00000102, 32'h00000000, 0, 32'h80017FFF, 1'b1, 32'hFFFF8001, 4'b1100, 32'h00000000);
    access(1'b1, 1'b0, 3'b101, 32'h00000100, 32'h00000000, 0, 32'h80017FFF, 1'b1, 32'h00007FFF, 4'b0011, 32'h00000000);
    access(1'b0, 1'b1, 3'b000, 32'h00000201, 32'h000000A5, 2, 32'h00000000, 1'b1, 32'h00000000, 4'b0010, 32'hA5A5A5A5);
    access(1'b0, 1'b1, 3'b001, 32'h00000201, 32'h00001111, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000);
    access(1'b0, 1'b1, 3'b100, 32'h00000200, 32'h00001111, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000);
    access(1'b1, 1'b1, 3'b010, 32'h00000400, 32'h11223344, 1, 32'hCAFEF00D, 1'b1, 32'h00000000, 4'b1111, 32'h11223344);
    access(1'b1, 1'b0, 3'b011, 32'h00000400, 32'h00000000, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000);
    access(1'b1, 1'b0, 3'b110, 32'h00000400, 32'h00000000, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 32'h00000000);
    access(1'b1, 1'b0, 3'b000, 32'h00000102, 32'h00000000, 0, 32'h00A50000, 1'b1, 32'hFFFFFFA5, 4'b0100, 32'h00000000);

    // reset during the third BUSY cycle of a load whose bus never answers
    @(negedge clk);
    exp_bus_q.push_back({1'b0, 4'b1111, 32'h00000500, 32'h00000000});
    mem_read = 1'b1;
    funct3 = 3'b010;
    address = 32'h00000500;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst mid bus_req", {31'b0, bus_req}, 32'd0);
    check("rst mid state", {30'b0, dbg_state}, {30'b0, IDLE});
    check("rst mid rdata", rdata, 32'h0);
    rst = 1'b0;
    mem_read = 1'b0;
    last_rdata = 32'h0;

    access(1'b1, 1'b0, 3'b010, 32'h00000700, 32'h00000000, 0, 32'h12345678, 1'b1, 32'h12345678, 4'b1111, 32'h00000000);

`ifdef LSU_TIMEOUT_EN
    // bus never answers: four BUSY cycles then an error completion with rdata cleared
    @(negedge clk);
    exp_bus_q.push_back({1'b0, 4'b1111, 32'h00000600, 32'h00000000});
    last_rdata = 32'h0;
    exp_rdata_q.push_back(32'h0);
    mem_read = 1'b1;
    funct3 = 3'b010;
    address = 32'h00000600;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("timeout stall", {31'b0, stall}, 32'd1);
      check("timeout bus_err low", {31'b0, bus_err}, 32'd0);
    end
    @(negedge clk); #1;
    check("timeout bus_err pulse", {31'b0, bus_err}, 32'd1);
    check("timeout bus_req dropped", {31'b0, bus_req}, 32'd0);
    check("timeout stall dropped", {31'b0, stall}, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    check("timeout bus_err cleared", {31'b0, bus_err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("expectations drained",
          32'(exp_rdata_q.size() + exp_bus_q.size() + exp_fault_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
